// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the piano sequencer.
// Mode state encoding, note-code width helper and the C4..C5 half-period
// table (in 100 MHz clocks) used by the tone divider.
package piano_pkg;

    typedef enum logic [1:0] {
        ST_LIVE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

    // Width of a half-period count; the largest table entry is 191110.
    localparam int unsigned HP_W = 18;

    // Number of tones held in the table (C4 at index 0 up to C5 at index 7).
    localparam int unsigned NUM_TONES = 8;

    // Half-period lookup; indices past the table reuse the highest tone.
    function automatic logic [HP_W-1:0] half_period(input int unsigned idx);
        case (idx)
            0:       return HP_W'(191110);
            1:       return HP_W'(170265);
            2:       return HP_W'(151685);
            3:       return HP_W'(143172);
            4:       return HP_W'(127551);
            5:       return HP_W'(113636);
            6:       return HP_W'(101239);
            default: return HP_W'(95557);
        endcase
    endfunction

    // Note code holds 0 (rest) plus one code per key.
    function automatic int unsigned note_w(input int unsigned keys);
        return $clog2(keys + 1);
    endfunction

endpackage

// File: rtl/tone_div.sv
// tone_div: square-wave generator with a programmable half-period.
// FREQ toggles every i_half_period clocks; a restart strobe or a low enable
// clears both the counter and the output.
module tone_div
    import piano_pkg::*;
#(
    parameter int unsigned W = HP_W
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_half_period,
    input  logic         i_restart,
    input  logic         i_enable,
    output logic         o_freq
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;
    logic         r_freq;

    // Half-period counter and output toggle; >= keeps a shrinking period safe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_freq <= 1'b0;
        end else if (i_restart || !i_enable) begin
            r_cnt  <= '0;
            r_freq <= 1'b0;
        end else if (r_cnt >= (i_half_period - ONE)) begin
            r_cnt  <= '0;
            r_freq <= ~r_freq;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_freq = r_freq;

endmodule

// File: rtl/piano_seq.sv
// piano_seq: key-switch tone generator with LIVE / RECORD / PLAY modes.
// Keys are priority-encoded (highest index wins), sampled once per tempo
// tick into a DEPTH-entry buffer while recording, and looped back in PLAY.
// Optional macro PIANO_OCTAVE_EN adds the OCT_UP input (one octave up).
module piano_seq
    import piano_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TICK_CYCLES = 25000000,
    parameter int unsigned DIV_SHIFT   = 0
)(
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             MODE,
    input  logic [NUM_KEYS-1:0]              sw,
`ifdef PIANO_OCTAVE_EN
    input  logic                             OCT_UP,
`endif
    output logic                             FREQ,
    output logic [NUM_KEYS-1:0]              Led,
    output logic [$clog2(NUM_KEYS+1)-1:0]    NOTE,
    output logic [1:0]                       STATE,
    output logic                             FULL
);

    localparam int unsigned NW = note_w(NUM_KEYS);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [LW-1:0]   DEPTH_L   = LW'(DEPTH);
    localparam logic [HP_W-1:0] HP_ONE    = HP_W'(1);

    // Input synchronisers
    logic [NUM_KEYS-1:0] r_sw_s1, r_sw_s2;
    logic                r_mode_s1, r_mode_s2, r_mode_s3;
    logic                w_mode_rise;

    // Mode FSM
    state_e r_state, w_state_nxt;
    logic   w_enter_rec, w_enter_play;

    // Tempo tick and buffer bookkeeping
    logic [TW-1:0] r_tick;
    logic          w_tick;
    logic          w_rec_wr;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [LW-1:0] r_len;
    logic          r_full;

    logic [NW-1:0] r_mem [DEPTH];
    logic [NW-1:0] r_rd_data;

    // Note path
    logic [NW-1:0]   w_live_code, w_note, r_note_d;
    logic [HP_W-1:0] w_hp;
    logic            w_restart;

    // Two-flop synchronisers plus one extra MODE stage for edge detection
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_s3 <= 1'b0;
        end else begin
            r_sw_s1   <= sw;
            r_sw_s2   <= r_sw_s1;
            r_mode_s1 <= MODE;
            r_mode_s2 <= r_mode_s1;
            r_mode_s3 <= r_mode_s2;
        end
    end

    assign w_mode_rise  = r_mode_s2 & ~r_mode_s3;
    assign w_enter_rec  = w_mode_rise && (r_state == ST_LIVE);
    assign w_enter_play = w_mode_rise && (r_state == ST_RECORD);

    // Mode state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= ST_LIVE;
        else        r_state <= w_state_nxt;
    end

    // Mode sequencing: LIVE -> RECORD -> PLAY -> LIVE; stray codes go to LIVE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LIVE:   if (w_mode_rise) w_state_nxt = ST_RECORD;
            ST_RECORD: if (w_mode_rise) w_state_nxt = ST_PLAY;
            ST_PLAY:   if (w_mode_rise) w_state_nxt = ST_LIVE;
            default:   w_state_nxt = ST_LIVE;
        endcase
    end

    // A mode edge suppresses a coincident tick so the sample is dropped
    assign w_tick = ((r_state == ST_RECORD) || (r_state == ST_PLAY)) &&
                    (r_tick == TICK_LAST) && !w_mode_rise;

    // Tempo counter, restarted on every mode change and idle in LIVE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tick <= '0;
        end else if (w_mode_rise ||
                     !((r_state == ST_RECORD) || (r_state == ST_PLAY))) begin
            r_tick <= '0;
        end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    // Highest-index pressed key wins; later iterations override earlier ones
    always_comb begin
        w_live_code = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (r_sw_s2[k]) w_live_code = NW'(k + 1);
        end
    end

    assign w_rec_wr = w_tick && (r_state == ST_RECORD) && (r_len != DEPTH_L);

    // Record pointer, length and full flag
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_full   <= 1'b0;
        end else if (w_enter_rec) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_full   <= 1'b0;
        end else if (w_rec_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_len    <= r_len + LW'(1);
            r_full   <= ((r_len + LW'(1)) == DEPTH_L);
        end
    end

    // Next playback pointer, wrapping after the last recorded entry
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_enter_play) begin
            w_rd_ptr_nxt = '0;
        end else if (w_tick && (r_state == ST_PLAY)) begin
            if ((LW'(r_rd_ptr) + LW'(1)) >= r_len) w_rd_ptr_nxt = '0;
            else                                   w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        end
    end

    // Playback pointer register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_rd_ptr <= '0;
        else        r_rd_ptr <= w_rd_ptr_nxt;
    end

    // Buffer write and registered read; reading at the next pointer keeps
    // r_rd_data aligned with r_rd_ptr without an extra cycle of lag
    always_ff @(posedge CLK) begin
        if (w_rec_wr) r_mem[r_wr_ptr] <= w_live_code;
        r_rd_data <= r_mem[w_rd_ptr_nxt];
    end

    // Sounding note selection per mode
    always_comb begin
        w_note = '0;
        case (r_state)
            ST_LIVE, ST_RECORD: w_note = w_live_code;
            ST_PLAY:            w_note = (r_len == '0) ? '0 : r_rd_data;
            default:            w_note = '0;
        endcase
    end

`ifdef PIANO_OCTAVE_EN
    logic r_oct_s1, r_oct_s2, r_oct_d;

    // OCT_UP synchroniser and change detector
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_oct_s1 <= 1'b0;
            r_oct_s2 <= 1'b0;
            r_oct_d  <= 1'b0;
        end else begin
            r_oct_s1 <= OCT_UP;
            r_oct_s2 <= r_oct_s1;
            r_oct_d  <= r_oct_s2;
        end
    end

    assign w_restart = (w_note != r_note_d) || (r_oct_s2 != r_oct_d);
`else
    assign w_restart = (w_note != r_note_d);
`endif

    // Half-period for the sounding key: key NUM_KEYS-1 maps to table index 0
    always_comb begin
        w_hp = half_period(NUM_KEYS - 32'(w_note)) >> DIV_SHIFT;
`ifdef PIANO_OCTAVE_EN
        if (r_oct_s2) w_hp = w_hp >> 1;
`endif
        if (w_hp == '0) w_hp = HP_ONE;
    end

    // Previous note, used to restart the divider on any change
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_note_d <= '0;
        else        r_note_d <= w_note;
    end

    tone_div #(
        .W (HP_W)
    ) u_tone_div (
        .i_clk         (CLK),
        .i_rst_n       (RESET),
        .i_half_period (w_hp),
        .i_restart     (w_restart),
        .i_enable      (w_note != '0),
        .o_freq        (FREQ)
    );

    // One-hot LED of the sounding key
    always_comb begin
        Led = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            Led[k] = (w_note == NW'(k + 1));
        end
    end

    assign NOTE  = w_note;
    assign STATE = r_state;
    assign FULL  = r_full;

endmodule

// File: doc/piano_seq.md
Name: piano_seq

Overview:
- Parametrised successor to the single-mode piano block.
- NUM_KEYS switch keyboard drives a square-wave tone output (FREQ) with three modes: LIVE (play keys directly), RECORD (sample the note at a fixed tempo into an internal buffer) and PLAY (loop the recorded sequence).
- Sits between the board switches/MODE button and the speaker pin. The LED driver and 7-segment driver consume NOTE and STATE.

Parameters:
- NUM_KEYS, 8: number of key switches; key NUM_KEYS-1 = C4 (lowest) down to key 0 = C5.
- DEPTH, 16: recording buffer entries; power of two.
- TICK_CYCLES, 25000000: clocks per tempo tick (record/playback step).
- DIV_SHIFT, 0: right shift applied to every half-period table entry. Simulation uses a nonzero value.

Ports:
- CLK, in, 1: system clock, 100 MHz nominal.
- RESET, in, 1: asynchronous, active-low reset.
- MODE, in, 1: debounced mode button; each rising edge advances the mode.
- sw, in, NUM_KEYS: key switches, 1 = pressed.
- FREQ, out, 1: square-wave tone.
- Led, out, NUM_KEYS: one-hot of the sounding key; 0 when silent.
- NOTE, out, $clog2(NUM_KEYS+1): sounding note code; 0 = rest, k+1 = key k.
- STATE, out, 2: 0 = LIVE, 1 = RECORD, 2 = PLAY.
- FULL, out, 1: recording buffer full.

Behaviour:
- Reset (RESET=0, async): STATE=LIVE; FREQ=0; Led=0; NOTE=0; FULL=0; all counters, pointers and recorded length = 0. Buffer contents are not cleared, but are unreachable because length = 0.
- Input sync: sw and MODE each pass through a 2-flop synchroniser. The MODE rising edge is detected on synced values, and STATE changes 3 clocks after MODE rises.
- Mode cycle: LIVE -> RECORD -> PLAY -> LIVE. Any other STATE encoding returns to LIVE.
- Entering RECORD: wr_ptr=0, length=0, FULL=0, tick counter=0.
- Entering PLAY: rd_ptr=0, tick counter=0.
- Key priority: the highest-index pressed key wins (lowest pitch). No key pressed gives code 0.
- LIVE: NOTE = priority code of the synced sw.
- RECORD:
  - NOTE = live code.
  - When the tick counter reaches TICK_CYCLES-1: write the code to buffer[wr_ptr], increment wr_ptr and length, and clear the counter. The first write occurs TICK_CYCLES clocks after entry.
  - When length reaches DEPTH, FULL=1 and further ticks write nothing.
- PLAY:
  - NOTE = buffer[rd_ptr]; the buffer uses a registered read.
  - On each tick, rd_ptr increments and wraps from length-1 to 0.
  - If length = 0, NOTE = 0 (silent) for the whole of PLAY.
  - The buffer is retained across PLAY -> LIVE -> next entry to PLAY only if RECORD is not re-entered.
- Tone divider:
  - Half-period HP = max(1, HALF_PERIOD[key] >> DIV_SHIFT).
  - The counter counts 0..HP-1. At HP-1, FREQ toggles and the counter clears, so the FREQ period is 2*HP clocks.
  - When NOTE changes, the counter = 0 and FREQ = 0 on the next clock.
  - When NOTE = 0, FREQ is held at 0.
- Led = one-hot(NOTE-1), or 0 when NOTE = 0.
- MODE edge coinciding with a tick: the mode change wins and the sample is discarded.

Optional Feature:
- Macro PIANO_OCTAVE_EN.
- Defined: adds input port OCT_UP (1 bit, 2-flop synced). While OCT_UP=1, HP is additionally shifted right by 1 (one octave up, minimum 1). A change of OCT_UP resets the divider exactly like a note change.
- Undefined: the port is absent and HP comes from the table only.

Decomposition:
- Package piano_pkg:
  - HALF_PERIOD table at 100 MHz for C4..C5: 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95557.
  - STATE encodings LIVE/RECORD/PLAY.
  - Note-code width function.
- Sub-module tone_div: inputs half-period, note-change strobe and enable; output FREQ.

Test Plan:
- Reset check (DIV_SHIFT=14, TICK_CYCLES=32): hold RESET=0, then release. Expect FREQ=0, Led=0, NOTE=0, STATE=0, FULL=0.
- LIVE C4: sw=8'h80. Expect NOTE=8, Led=8'h80, HP=11, and FREQ toggling every 11 clocks (period 22).
- LIVE priority/change: sw=8'h81 gives NOTE=8. Then sw=8'h01 gives NOTE=1, HP=5; FREQ goes to 0 and the counter restarts with period 10.
- RECORD/PLAY: pulse MODE and check STATE=1 after 3 clocks. Hold sw=8'h20 for 2 ticks, then 8'h10 for 1 tick, then pulse MODE. Expect STATE=2 and NOTE sequence 6,6,5,6,6,5,…, each held 32 clocks.
- FULL: in RECORD hold any key for 20 ticks. Expect FULL=1 after the 16th write and PLAY looping exactly 16 entries.
- Empty PLAY, then reset mid-PLAY:
  - Enter RECORD and immediately pulse MODE again. Expect PLAY silent (FREQ=0, NOTE=0).
  - Assert RESET mid-PLAY. Expect immediate return to the reset values.
